program_sequencer: RTL and testbench

- Instruction sequencer that drives the 20-bit opcode executor.
- Fetches opcodes from a synchronous program ROM using a program counter, issues each one to the executor, and waits on its Done handshake.
- Resolves its own control opcodes (halt, jump, jump-if-zero) locally; they are never sent to the executor.
- Sits between program memory and the executor in the top-level machine.

---
 rtl/program_sequencer.sv | 147 ++++++++++++++
 tb/tb_program_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches from a synchronous program ROM, resolves control opcodes locally
// and issues the remaining opcodes to the executor with a Done handshake. Optional macro: SEQ_STEP_EN.
module program_sequencer #(
  parameter int A   = 8,
  parameter int W   = 20,
  parameter int TMO = 15
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
`ifdef SEQ_STEP_EN
  input  logic         Step,
`endif
  output logic [A-1:0] ProgAddr,
  input  logic [W-1:0] ProgData,
  output logic [W-1:0] ExecOpCode,
  input  logic         ExecDone,
  input  logic         ExecZero,
  output logic [A-1:0] PC,
  output logic [15:0]  InstrCount,
  output logic         Running,
  output logic         Halted,
  output logic         Fault
);

  localparam int WDW = $clog2(TMO + 1);

  localparam logic [3:0] op_halt = 4'h0;
  localparam logic [3:0] op_jz   = 4'hE;
  localparam logic [3:0] op_jmp  = 4'hF;

`ifdef SEQ_STEP_EN
  typedef enum logic [2:0] {
    st_idle, st_fetch, st_decode, st_exec, st_halt, st_fault, st_pause
  } state_t;
`else
  typedef enum logic [2:0] {
    st_idle, st_fetch, st_decode, st_exec, st_halt, st_fault
  } state_t;
`endif

  state_t         state_reg, state_next;
  logic [A-1:0]   pc_reg, pc_next;
  logic [W-1:0]   ir_reg, ir_next;
  logic [15:0]    count_reg, count_next;
  logic [WDW-1:0] wdog_reg, wdog_next;
  logic [3:0]     opcode;
  logic           first_exec;

  assign opcode = ProgData[W-1 -: 4];
  // The watchdog is zero on every entry to EXEC, so it doubles as the first-cycle marker.
  assign first_exec = (wdog_reg == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= st_idle;
      pc_reg    <= '0;
      ir_reg    <= '0;
      count_reg <= '0;
      wdog_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      count_reg <= count_next;
      wdog_reg  <= wdog_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    count_next = count_reg;
    wdog_next  = wdog_reg;
    ExecOpCode = '0;
    case (state_reg)
      st_idle, st_halt, st_fault: begin
        if (Start) begin
          pc_next    = '0;
          count_next = '0;
          wdog_next  = '0;
          state_next = st_fetch;
        end
      end
      st_fetch: state_next = st_decode;
      st_decode: begin
        ir_next = ProgData;
        case (opcode)
          op_halt: state_next = st_halt;
          op_jmp: begin
            pc_next    = A'(ProgData[7:0]);
            state_next = st_fetch;
          end
          op_jz: begin
            pc_next    = ExecZero ? A'(ProgData[7:0]) : pc_reg + 1'b1;
            state_next = st_fetch;
          end
          default: begin
            pc_next    = pc_reg + 1'b1;
            wdog_next  = '0;
`ifdef SEQ_STEP_EN
            state_next = st_pause;
`else
            state_next = st_exec;
`endif
          end
        endcase
      end
`ifdef SEQ_STEP_EN
      st_pause: begin
        if (Step) state_next = st_exec;
      end
`endif
      st_exec: begin
        // Dropping the opcode as soon as Done returns keeps the executor from re-running it.
        if (first_exec || !ExecDone) ExecOpCode = ir_reg;
        if (!first_exec && ExecDone) begin
          count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
          wdog_next  = '0;
          state_next = st_fetch;
        end else if (wdog_reg == WDW'(TMO - 1)) begin
          wdog_next  = '0;
          state_next = st_fault;
        end else begin
          wdog_next  = wdog_reg + 1'b1;
        end
      end
      default: state_next = st_idle;
    endcase
  end

  assign ProgAddr   = pc_reg;
  assign PC         = pc_reg;
  assign InstrCount = count_reg;
  assign Halted     = (state_reg == st_halt);
  assign Fault      = (state_reg == st_fault);
`ifdef SEQ_STEP_EN
  // A paused program is still mid-run, so it reports as Running.
  assign Running = (state_reg == st_fetch) || (state_reg == st_decode) ||
                   (state_reg == st_exec)  || (state_reg == st_pause);
`else
  assign Running = (state_reg == st_fetch) || (state_reg == st_decode) ||
                   (state_reg == st_exec);
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: ROM and executor models, issue queue checked on each new opcode.
module tb_program_sequencer;
  localparam int A = 8;
  localparam int W = 20;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [A-1:0] ProgAddr;
  logic [W-1:0] ProgData;
  logic [W-1:0] ExecOpCode;
  logic         ExecDone;
  logic         ExecZero;
  logic [A-1:0] PC;
  logic [15:0]  InstrCount;
  logic         Running;
  logic         Halted;
  logic         Fault;
`ifdef SEQ_STEP_EN
  logic         Step;
`endif

  always #5 Clock = ~Clock;

  program_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
`ifdef SEQ_STEP_EN
    .Step(Step),
`endif
    .ProgAddr(ProgAddr), .ProgData(ProgData), .ExecOpCode(ExecOpCode),
    .ExecDone(ExecDone), .ExecZero(ExecZero), .PC(PC), .InstrCount(InstrCount),
    .Running(Running), .Halted(Halted), .Fault(Fault)
  );

  logic [W-1:0] rom [0:255];
  always @(posedge Clock) ProgData <= rom[ProgAddr];

  // Executor model: latches a nonzero opcode while idle, holds Done low for lat cycles.
  bit hang = 1'b0;
  int lat  = 2;
  int cnt;
  bit busy;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy     <= 1'b0;
      ExecDone <= 1'b1;
      cnt      <= 0;
    end else if (!busy) begin
      if (ExecOpCode != '0) begin
        busy     <= 1'b1;
        ExecDone <= 1'b0;
        cnt      <= lat;
      end
    end else if (!hang) begin
      if (cnt <= 1) begin
        busy     <= 1'b0;
        ExecDone <= 1'b1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Issue monitor: every rising opcode pops the scoreboard.
  logic [W-1:0] prev_op   = '0;
  logic         prev_done = 1'b1;
  always @(negedge Clock) begin
    logic [W-1:0] e;
    if (ExecOpCode != '0 && prev_op == '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 32'(ExecOpCode), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("issue", 32'(ExecOpCode), 32'(e));
      end
      $display("issue opcode=0x%05h pc=%0d count=%0d t=%0t", ExecOpCode, PC, InstrCount, $time);
    end else if (ExecOpCode != '0 && prev_op != '0) begin
      check("hold", 32'(ExecOpCode), 32'(prev_op));
    end
    if (ExecDone && !prev_done) check("drop_on_done", 32'(ExecOpCode), 32'h0);
    prev_op   = ExecOpCode;
    prev_done = ExecDone;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pulse_start;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic run_to_end(input string tag, output int n);
    n = 0;
    while (!(Halted || Fault) && n < 500) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_end"}, 32'(Halted | Fault), 32'h1);
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (ExecOpCode == '0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_issue_seen"}, 32'(ExecOpCode != '0), 32'h1);
  endtask

  task automatic expect_end(input string tag, input logic h, input int pc, input int cntv);
    check({tag, "_halted"}, 32'(Halted), 32'(h));
    check({tag, "_pc"}, 32'(PC), 32'(pc));
    check({tag, "_count"}, 32'(InstrCount), 32'(cntv));
    check({tag, "_queue"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    ExecZero = 1'b0;
`ifdef SEQ_STEP_EN
    Step = 1'b0;
`endif
    clear_rom();
    tick(2);
    check("rst_opcode", 32'(ExecOpCode), 32'h0);
    check("rst_progaddr", 32'(ProgAddr), 32'h0);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_count", 32'(InstrCount), 32'h0);
    check("rst_flags", {29'h0, Running, Halted, Fault}, 32'h0);
    Reset = 1'b0;
    tick(3);
    check("idle_stays", {29'h0, Running, Halted, Fault}, 32'h0);

    // Straight program with end-to-end latency
    rom[0] = 20'h10005; rom[1] = 20'h30003; rom[2] = 20'h00000;
    exp_q.push_back(20'h10005); exp_q.push_back(20'h30003);
    pulse_start();
    run_to_end("straight", n);
    check("straight_latency", 32'(n), 32'd14);
    expect_end("straight", 1'b1, 2, 2);

    // Restart clears the count; Start during EXEC is ignored
    exp_q.push_back(20'h10005); exp_q.push_back(20'h30003);
    pulse_start();
    wait_issue("busy_start");
    pulse_start();
    run_to_end("busy_start", n);
    expect_end("busy_start", 1'b1, 2, 2);

    // Jump is resolved locally
    clear_rom();
    rom[0] = 20'hF0004; rom[1] = 20'h10001; rom[4] = 20'h00000;
    pulse_start();
    run_to_end("jmp", n);
    expect_end("jmp", 1'b1, 4, 0);

    // Jump-if-zero taken and not taken
    clear_rom();
    rom[0] = 20'hF0003; rom[3] = 20'hE0009; rom[4] = 20'h20011; rom[9] = 20'h00000;
    ExecZero = 1'b1;
    pulse_start();
    run_to_end("jz_taken", n);
    expect_end("jz_taken", 1'b1, 9, 0);
    ExecZero = 1'b0;
    exp_q.push_back(20'h20011);
    pulse_start();
    run_to_end("jz_not", n);
    expect_end("jz_not", 1'b1, 5, 1);

    // PC wraps from the last address back to 0
    clear_rom();
    rom[0] = 20'hE00FF; rom[255] = 20'h40001;
    ExecZero = 1'b1;
    exp_q.push_back(20'h40001);
    pulse_start();
    wait_issue("wrap");
    check("wrap_pc_after_last", 32'(PC), 32'h0);
    ExecZero = 1'b0;
    run_to_end("wrap", n);
    expect_end("wrap", 1'b1, 1, 1);

    // Watchdog fault, then recovery through Start
    clear_rom();
    rom[0] = 20'h50001;
    hang = 1'b1;
    exp_q.push_back(20'h50001);
    pulse_start();
    wait_issue("wdog");
    n = 0;
    while (!Fault && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check("wdog_cycles", 32'(n), 32'd15);
    check("wdog_fault", 32'(Fault), 32'h1);
    check("wdog_opcode", 32'(ExecOpCode), 32'h0);
    check("wdog_running", 32'(Running), 32'h0);
    check("wdog_count", 32'(InstrCount), 32'h0);
    hang = 1'b0;
    tick(4);
    check("wdog_fault_held", 32'(Fault), 32'h1);
    exp_q.push_back(20'h50001);
    pulse_start();
    check("recover_fault", 32'(Fault), 32'h0);
    check("recover_running", 32'(Running), 32'h1);
    check("recover_pc", 32'(PC), 32'h0);
    run_to_end("recover", n);
    expect_end("recover", 1'b1, 1, 1);

    // Reset in the middle of EXEC
    hang = 1'b1;
    exp_q.push_back(20'h50001);
    pulse_start();
    wait_issue("rst_exec");
    tick(3);
    check("rst_exec_held", 32'(ExecOpCode), 32'h50001);
    #2 Reset = 1'b1;
    #1;
    check("rst_exec_opcode", 32'(ExecOpCode), 32'h0);
    check("rst_exec_pc", 32'(PC), 32'h0);
    check("rst_exec_flags", {29'h0, Running, Halted, Fault}, 32'h0);
    tick(1);
    Reset = 1'b0;
    hang = 1'b0;
    tick(3);
    check("rst_exec_idle", {29'h0, Running, Halted, Fault}, 32'h0);
    check("rst_exec_queue", 32'(exp_q.size()), 32'h0);

`ifdef SEQ_STEP_EN
    // Single-step pause before execution
    clear_rom();
    rom[0] = 20'h10005;
    exp_q.push_back(20'h10005);
    pulse_start();
    tick(10);
    check("step_wait_opcode", 32'(ExecOpCode), 32'h0);
    check("step_wait_running", 32'(Running), 32'h1);
    Step = 1'b1;
    tick(1);
    Step = 1'b0;
    run_to_end("step", n);
    expect_end("step", 1'b1, 1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
